// File: rtl/mpmc11_pkg.sv
// Shared types and constants for the mpmc11 memory controller.
package mpmc11_pkg;

    // Default number of load-reserved/store-conditional reservation entries
    localparam int unsigned NAR = 4;

    // Owner value of an invalid entry; channel 15 never issues requests
    localparam logic [3:0] NO_CH = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        RD_CMD,
        RD_DATA,
        WR_CMD,
        WR_DATA
    } mpmc11_state_t;

    typedef struct packed {
        logic        valid;
        logic [3:0]  ch;
        logic [26:0] blk;
        logic [15:0] tmo;
    } mpmc11_resv_t;

    // Population count of up to 16 flags
    function automatic logic [4:0] popcnt16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/mpmc11_resv_alloc.sv
// Picks the reservation entry a reserving read writes into: the channel's own
// entry, else the lowest free entry, else the round-robin victim.
module mpmc11_resv_alloc #(
    parameter int unsigned NAR = 4,
    parameter int unsigned IW  = $clog2(NAR)
) (
    input  logic [NAR-1:0] valid_i,
    input  logic [NAR-1:0] own_hit_i,
    input  logic [IW-1:0]  victim_i,
    output logic [IW-1:0]  idx_o,
    output logic           evict_o
);

    logic free_found;

    // Target selection: owner hit beats free slot beats eviction
    always_comb begin
        idx_o      = victim_i;
        evict_o    = 1'b1;
        free_found = 1'b0;
        for (int i = 0; i < int'(NAR); i++) begin
            if (!free_found && !valid_i[i]) begin
                idx_o      = IW'(i);
                free_found = 1'b1;
            end
        end
        if (free_found) begin
            evict_o = 1'b0;
        end
        // A channel owns at most one entry, so at most one bit is set here
        for (int i = 0; i < int'(NAR); i++) begin
            if (own_hit_i[i]) begin
                idx_o   = IW'(i);
                evict_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mpmc11_resv_table.sv
// LR/SC reservation table: sets an entry on a reserving read, drops entries on
// effective writes to the same 32-byte block, on timeout, or on flush.
module mpmc11_resv_table #(
    parameter int unsigned NAR      = mpmc11_pkg::NAR,
    parameter int unsigned RESV_TMO = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  mpmc11_pkg::mpmc11_state_t    state,
    input  logic                         go,
    input  logic [3:0]                   ch,
    input  logic                         we,
    input  logic                         sr,
    input  logic                         cr,
    input  logic [31:0]                  adr,
    input  logic                         clr_all,
    output logic [4*NAR-1:0]             resv_ch,
    output logic [32*NAR-1:0]            resv_adr,
    output logic [$clog2(NAR):0]         resv_cnt,
    output logic                         cr_ok
);

    import mpmc11_pkg::*;

    localparam int unsigned IW = $clog2(NAR);
    localparam int unsigned CW = IW + 1;
    localparam logic [15:0] TmoLoad = 16'(RESV_TMO);
    localparam mpmc11_resv_t EntInvalid = '{valid: 1'b0, ch: NO_CH, blk: '0, tmo: '0};

    mpmc11_resv_t ent_q [NAR];
    mpmc11_resv_t ent_d [NAR];
    logic [IW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic           upd;
    logic [26:0]    blk_in;
    logic [NAR-1:0] valid_vec;
    logic [NAR-1:0] own_hit;
    logic [NAR-1:0] blk_hit;
    logic [IW-1:0]  tgt_idx;
    logic           tgt_evict;
    logic           wr_eff;
    logic           unused_adr_lo;

    // Byte offset within the block never affects matching
    assign unused_adr_lo = ^adr[4:0];

    assign upd    = go && (state == IDLE);
    assign blk_in = adr[31:5];

    // Per-entry match vectors against the pre-update table
    always_comb begin
        valid_vec = '0;
        own_hit   = '0;
        blk_hit   = '0;
        for (int i = 0; i < int'(NAR); i++) begin
            valid_vec[i] = ent_q[i].valid;
            own_hit[i]   = ent_q[i].valid && (ent_q[i].ch == ch);
            blk_hit[i]   = ent_q[i].valid && (ent_q[i].blk == blk_in);
        end
    end

    assign cr_ok  = we && cr && (|(own_hit & blk_hit));
    assign wr_eff = upd && we && (!cr || cr_ok);

    mpmc11_resv_alloc #(
        .NAR (NAR),
        .IW  (IW)
    ) u_alloc (
        .valid_i   (valid_vec),
        .own_hit_i (own_hit),
        .victim_i  (ptr_q),
        .idx_o     (tgt_idx),
        .evict_o   (tgt_evict)
    );

    // Next table state; later assignments take priority over earlier ones
    always_comb begin
        logic [15:0] v16;
        ent_d = ent_q;
        ptr_d = ptr_q;

        // Ageing: lowest priority, overridden by a same-cycle set below
        if (RESV_TMO != 0) begin
            for (int i = 0; i < int'(NAR); i++) begin
                if (ent_q[i].valid) begin
                    if (ent_q[i].tmo == 16'd1) begin
                        ent_d[i] = EntInvalid;
                    end else if (ent_q[i].tmo != 16'd0) begin
                        ent_d[i].tmo = ent_q[i].tmo - 16'd1;
                    end
                end
            end
        end

        if (wr_eff) begin
            // Any channel's reservation on the written block is lost
            for (int i = 0; i < int'(NAR); i++) begin
                if (blk_hit[i]) begin
                    ent_d[i] = EntInvalid;
                end
            end
        end else if (upd && !we && sr) begin
            ent_d[tgt_idx] = '{valid: 1'b1, ch: ch, blk: blk_in, tmo: TmoLoad};
            if (tgt_evict) begin
                ptr_d = ptr_q + IW'(1);
            end
        end

        // Flush wins over everything, and suppresses the victim advance too
        if (clr_all) begin
            for (int i = 0; i < int'(NAR); i++) begin
                ent_d[i] = EntInvalid;
            end
            ptr_d = ptr_q;
        end

        v16 = '0;
        for (int i = 0; i < int'(NAR); i++) begin
            v16[i] = ent_d[i].valid;
        end
        cnt_d = CW'(popcnt16(v16));
    end

    // Table, victim pointer and registered population count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NAR); i++) begin
                ent_q[i] <= EntInvalid;
            end
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ent_q <= ent_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Invalid entries are stored canonically (NO_CH, block 0)
    always_comb begin
        resv_ch  = '0;
        resv_adr = '0;
        for (int i = 0; i < int'(NAR); i++) begin
            resv_ch[4*i +: 4]   = ent_q[i].ch;
            resv_adr[32*i +: 32] = {ent_q[i].blk, 5'b00000};
        end
    end

    assign resv_cnt = cnt_q;

endmodule

// File: tb/tb_mpmc11_resv_table.sv
// Bench for mpmc11_resv_table: two instances (no timeout, 8-clock timeout) share
// one directed stimulus and are compared every cycle against a table model.
module tb_mpmc11_resv_table;
    import mpmc11_pkg::*;

    localparam int NE    = 4;
    localparam int TMO_B = 8;

    logic clk = 1'b0;
    logic rst_n;
    mpmc11_state_t state;
    logic go, we, sr, cr, clr_all;
    logic [3:0] ch;
    logic [31:0] adr;

    logic [4*NE-1:0]  resv_ch0, resv_ch1;
    logic [32*NE-1:0] resv_adr0, resv_adr1;
    logic [2:0]       cnt0, cnt1;
    logic             crok0, crok1;

    always #5 clk = ~clk;

    mpmc11_resv_table #(.NAR(NE), .RESV_TMO(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .state(state), .go(go), .ch(ch), .we(we), .sr(sr),
        .cr(cr), .adr(adr), .clr_all(clr_all), .resv_ch(resv_ch0), .resv_adr(resv_adr0),
        .resv_cnt(cnt0), .cr_ok(crok0)
    );

    mpmc11_resv_table #(.NAR(NE), .RESV_TMO(TMO_B)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .state(state), .go(go), .ch(ch), .we(we), .sr(sr),
        .cr(cr), .adr(adr), .clr_all(clr_all), .resv_ch(resv_ch1), .resv_adr(resv_adr1),
        .resv_cnt(cnt1), .cr_ok(crok1)
    );

    int unsigned vecs = 0;
    int unsigned errs = 0;

    // Reference table: one per instance
    bit          m_v   [2][NE];
    int          m_ch  [2][NE];
    logic [26:0] m_blk [2][NE];
    int          m_t   [2][NE];
    int          m_ptr [2];

    function automatic int tmo_of(int d);
        return (d == 1) ? TMO_B : 0;
    endfunction

    function automatic bit m_crok(int d);
        if (!(we && cr)) return 1'b0;
        for (int i = 0; i < NE; i++)
            if (m_v[d][i] && m_ch[d][i] == int'(ch) && m_blk[d][i] == adr[31:5]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_cnt(int d);
        int n = 0;
        for (int i = 0; i < NE; i++) n += int'(m_v[d][i]);
        return n;
    endfunction

    function automatic logic [3:0] m_ech(int d, int i);
        return m_v[d][i] ? 4'(m_ch[d][i]) : 4'hF;
    endfunction

    function automatic logic [31:0] m_eadr(int d, int i);
        return m_v[d][i] ? {m_blk[d][i], 5'b0} : 32'h0;
    endfunction

    function automatic logic [3:0] d_ch(int d, int i);
        return (d == 1) ? resv_ch1[4*i +: 4] : resv_ch0[4*i +: 4];
    endfunction

    function automatic logic [31:0] d_adr(int d, int i);
        return (d == 1) ? resv_adr1[32*i +: 32] : resv_adr0[32*i +: 32];
    endfunction

    task automatic m_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < NE; i++) begin
                m_v[d][i] = 1'b0; m_ch[d][i] = 15; m_blk[d][i] = '0; m_t[d][i] = 0;
            end
            m_ptr[d] = 0;
        end
    endtask

    // One clock edge of the table rules, applied to instance d
    task automatic m_step(int d);
        bit upd, ok, ev;
        int tgt;
        upd = go && (state == IDLE);
        if (clr_all) begin
            for (int i = 0; i < NE; i++) m_v[d][i] = 1'b0;
            return;
        end
        ok = m_crok(d);
        tgt = -1;
        ev  = 1'b0;
        for (int i = 0; i < NE; i++)
            if (tgt < 0 && m_v[d][i] && m_ch[d][i] == int'(ch)) tgt = i;
        for (int i = 0; i < NE; i++)
            if (tgt < 0 && !m_v[d][i]) tgt = i;
        if (tgt < 0) begin
            tgt = m_ptr[d];
            ev  = 1'b1;
        end
        if (tmo_of(d) > 0) begin
            for (int i = 0; i < NE; i++) begin
                if (m_v[d][i]) begin
                    if (m_t[d][i] == 1) m_v[d][i] = 1'b0;
                    else m_t[d][i] = m_t[d][i] - 1;
                end
            end
        end
        if (upd && we) begin
            if (!cr || ok)
                for (int i = 0; i < NE; i++)
                    if (m_blk[d][i] == adr[31:5]) m_v[d][i] = 1'b0;
        end else if (upd && sr) begin
            m_v[d][tgt]   = 1'b1;
            m_ch[d][tgt]  = int'(ch);
            m_blk[d][tgt] = adr[31:5];
            m_t[d][tgt]   = tmo_of(d);
            if (ev) m_ptr[d] = (m_ptr[d] + 1) % NE;
        end
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model update on every edge; asynchronous reset mirrored immediately
    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else begin
                m_step(0);
                m_step(1);
            end
        end
    end

    // Every-cycle comparison away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < NE; i++) begin
                    check($sformatf("dut%0d resv_ch[%0d]", d, i), 32'(d_ch(d, i)), 32'(m_ech(d, i)));
                    check($sformatf("dut%0d resv_adr[%0d]", d, i), d_adr(d, i), m_eadr(d, i));
                end
                check($sformatf("dut%0d resv_cnt", d), (d == 1) ? 32'(cnt1) : 32'(cnt0),
                      32'(m_cnt(d)));
                check($sformatf("dut%0d cr_ok", d), (d == 1) ? 32'(crok1) : 32'(crok0),
                      32'(m_crok(d)));
            end
        end
    end

    task automatic idle_in();
        go = 0; we = 0; sr = 0; cr = 0; clr_all = 0; state = IDLE; ch = 4'd0; adr = '0;
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One request cycle; returns cr_ok of instance 0 sampled mid-cycle
    task automatic op(input logic [3:0] c, input logic w, input logic s, input logic k,
                      input logic [31:0] a, input logic clr, output logic ok0);
        go = 1; ch = c; we = w; sr = s; cr = k; adr = a; clr_all = clr;
        #3 ok0 = crok0;
        @(posedge clk);
        #1;
        idle_in();
    endtask

    initial begin
        logic ok;
        idle_in();
        rst_n = 1'b0;
        tick(2);
        check("rst cnt", 32'(cnt0), 0);
        check("rst ch0", 32'(d_ch(0, 0)), 32'hF);
        check("rst adr0", d_adr(0, 0), 32'h0);
        rst_n = 1'b1;
        tick(1);

        op(4'd3, 0, 1, 0, 32'h1000_0040, 0, ok);
        check("set ch", 32'(d_ch(0, 0)), 3);
        check("set adr", d_adr(0, 0), 32'h1000_0040);
        check("set cnt", 32'(cnt0), 1);
        check("set other free", 32'(d_ch(0, 1)), 32'hF);
        check("model set cnt", 32'(m_cnt(0)), 1);

        op(4'd3, 1, 0, 1, 32'h1000_0050, 0, ok);
        check("sc ok", 32'(ok), 1);
        check("sc consumed", 32'(d_ch(0, 0)), 32'hF);
        check("sc cnt", 32'(cnt0), 0);

        op(4'd5, 0, 1, 0, 32'h2000_0000, 0, ok);
        op(4'd3, 1, 0, 1, 32'h2000_0000, 0, ok);
        check("sc fail", 32'(ok), 0);
        check("sc fail keeps ch", 32'(d_ch(0, 0)), 5);
        check("sc fail keeps adr", d_adr(0, 0), 32'h2000_0000);

        op(4'd3, 0, 1, 0, 32'h3000_0020, 0, ok);
        check("lowest free", 32'(d_ch(0, 1)), 3);
        op(4'd5, 1, 0, 0, 32'h3000_003C, 0, ok);
        check("wr inval", 32'(d_ch(0, 1)), 32'hF);
        check("wr keeps other", 32'(d_ch(0, 0)), 5);
        check("wr cnt", 32'(cnt0), 1);

        op(4'd3, 0, 1, 0, 32'h4000_0000, 0, ok);
        op(4'd3, 0, 1, 0, 32'h4000_1000, 0, ok);
        check("own reuse adr", d_adr(0, 1), 32'h4000_1000);
        check("own reuse cnt", 32'(cnt0), 2);
        check("own no spill", 32'(d_ch(0, 2)), 32'hF);

        state = RD_CMD;
        op(4'd7, 0, 1, 0, 32'h4100_0000, 0, ok);
        check("busy no set", 32'(cnt0), 2);
        op(4'd9, 0, 0, 0, 32'h5555_0000, 0, ok);
        check("read no sr", 32'(cnt0), 2);
        op(4'd0, 0, 0, 0, 32'h0, 1, ok);
        check("clr cnt", 32'(cnt0), 0);

        for (int k = 0; k < 4; k++) op(4'(k), 0, 1, 0, 32'h5000_0000 + 32'(k << 8), 0, ok);
        check("full cnt", 32'(cnt0), 4);
        op(4'd4, 0, 1, 0, 32'h5000_0400, 0, ok);
        check("evict e0", 32'(d_ch(0, 0)), 4);
        check("evict keeps e1", 32'(d_ch(0, 1)), 1);
        check("evict cnt", 32'(cnt0), 4);
        for (int k = 5; k < 9; k++) begin
            op(4'(k), 0, 1, 0, 32'h5000_0000 + 32'(k << 8), 0, ok);
            check($sformatf("evict ch%0d", k), 32'(d_ch(0, (k - 4) % 4)), 32'(k));
        end

        op(4'd0, 0, 0, 0, 32'h0, 1, ok);
        op(4'd1, 0, 1, 0, 32'h6000_0000, 0, ok);
        op(4'd2, 0, 1, 0, 32'h6000_0010, 0, ok);
        check("two same blk", 32'(cnt0), 2);
        op(4'd0, 1, 0, 0, 32'h6000_0004, 0, ok);
        check("multi inval", 32'(cnt0), 0);

        // Timeout: set, expiry after 8 edges
        op(4'd1, 0, 1, 0, 32'h7000_0000, 0, ok);
        tick(7);
        check("tmo alive", 32'(cnt1), 1);
        tick(1);
        check("tmo expired", 32'(cnt1), 0);
        check("tmo ch", 32'(d_ch(1, 0)), 32'hF);
        check("no tmo kept", 32'(cnt0), 1);

        // Re-set at t+7 pushes expiry to t+15
        op(4'd1, 0, 1, 0, 32'h7000_0000, 0, ok);
        tick(6);
        op(4'd1, 0, 1, 0, 32'h7000_0000, 0, ok);
        tick(7);
        check("tmo reload alive", 32'(cnt1), 1);
        tick(1);
        check("tmo reload expired", 32'(cnt1), 0);

        // Set in the expiring cycle wins
        op(4'd1, 0, 1, 0, 32'h7000_0000, 0, ok);
        tick(7);
        op(4'd1, 0, 1, 0, 32'h7000_0020, 0, ok);
        check("set beats expiry cnt", 32'(cnt1), 1);
        check("set beats expiry adr", d_adr(1, 0), 32'h7000_0020);

        op(4'd2, 0, 1, 0, 32'h7100_0000, 1, ok);
        check("clr+set cnt0", 32'(cnt0), 0);
        check("clr+set cnt1", 32'(cnt1), 0);
        check("clr+set ch", 32'(d_ch(0, 0)), 32'hF);

        op(4'd3, 0, 1, 0, 32'h7200_0000, 0, ok);
        check("pre async cnt", 32'(cnt0), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async cnt0", 32'(cnt0), 0);
        check("async ch0", 32'(d_ch(0, 0)), 32'hF);
        check("async cnt1", 32'(cnt1), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
